vga_sync: RTL and testbench
===========================

VGA_SYNC -- requirements
Module: vga_sync

Interface
REQ-001 Parameter HD, 640, horizontal visible pixels.
REQ-002 Parameter HF, 16, horizontal front porch, in pixels.
REQ-003 Parameter HR, 96, horizontal sync pulse width, in pixels.
REQ-004 Parameter HB, 48, horizontal back porch, in pixels.
REQ-005 Parameter VD, 480, vertical visible lines.
REQ-006 Parameter VF, 10, vertical front porch, in lines.
REQ-007 Parameter VR, 2, vertical sync pulse width, in lines.
REQ-008 Parameter VB, 33, vertical back porch, in lines.
REQ-009 Parameter TICK_DIV, 4, system clocks per pixel.
REQ-010 Clock and reset: one clock; reset is synchronous and active-high.
REQ-011 clk  input  1  system clock, 100 MHz nominal; all state updates on the rising edge.
REQ-012 reset  input  1  synchronous active-high reset.
REQ-013 hsync  output  1  horizontal sync, active-low.
REQ-014 vsync  output  1  vertical sync, active-low.
REQ-015 video_on  output  1  high while the current pixel is in the visible area.
REQ-016 utick  output  1  pixel-rate enable, one clk wide, once every TICK_DIV clocks.
REQ-017 pixel_x  output  10  current horizontal pixel count.
REQ-018 pixel_y  output  10  current vertical line count.

Function
REQ-019 A mod-TICK_DIV divider counts every clk; utick SHALL be high exactly while the divider equals TICK_DIV-1.
REQ-020 pixel_x SHALL increment only on clk edges where utick=1.
REQ-021 pixel_x SHALL wrap from HD+HF+HR+HB-1 (799) to 0.
REQ-022 pixel_y SHALL increment only on the edge where pixel_x wraps.
REQ-023 pixel_y SHALL wrap from VD+VF+VR+VB-1 (524) to 0 on that same edge.
REQ-024 Simultaneous wrap at (799,524) SHALL yield (0,0) on one edge.
REQ-025 hsync SHALL be 0 exactly while 656 <= pixel_x <= 751, i.e. HD+HF to HD+HF+HR-1; it is 1 otherwise.
REQ-026 vsync SHALL be 0 exactly while 490 <= pixel_y <= 491, i.e. VD+VF to VD+VF+VR-1; it is 1 otherwise.
REQ-027 hsync and vsync SHALL be registered outputs, computed from the next-state counter values, so they change on the same clk edge as pixel_x/pixel_y and are glitch-free.
REQ-028 video_on SHALL equal (pixel_x < HD) AND (pixel_y < VD), with zero latency relative to the counters.
REQ-029 Pixel and line counters SHALL be 10 bits wide; counts SHALL never exceed 799 horizontally or 524 vertically.
REQ-030 Line period SHALL be 800 ticks (3200 clk); frame period SHALL be 525 lines (1,680,000 clk = 16.8 ms at 100 MHz).

Reset
REQ-031 While reset=1 at a clk edge, the module SHALL load: divider=0, pixel_x=0, pixel_y=0, hsync=1, vsync=1.
REQ-032 Consequently, during and immediately after reset, utick=0 and video_on=1.
REQ-033 The first utick SHALL occur in the 4th clk cycle after the first edge sampling reset=0, i.e. at divider=3.
REQ-034 Reset asserted mid-frame SHALL override counting, with no partial-line completion.

Structure
REQ-035 A shared package SHALL hold the VGA 640x480 timing constants and derived totals: H_TOTAL=800, V_TOTAL=525, sync start/end values.
REQ-036 One sub-module, vga_mod_counter, SHALL implement a parameterised modulo-N counter with enable, synchronous reset, count and wrap outputs.
REQ-037 vga_mod_counter SHALL be instantiated three times: divider, horizontal counter and vertical counter.
REQ-038 The sync registers and the video_on decode SHALL reside in the top level.

Verification
REQ-039 Reset scenario: clk 10 ns, reset=1 for 100 ns -> throughout reset, pixel_x=0, pixel_y=0, hsync=1, vsync=1, video_on=1, utick=0.
REQ-040 Tick scenario: release reset -> utick pulses 1 clk wide every 40 ns; pixel_x goes 0,1,2 at consecutive ticks.
REQ-041 Line scenario: hsync falls when pixel_x reaches 656 and rises when it reaches 752 (3840 ns low).
REQ-042 Line scenario, continued: video_on falls at pixel_x=640; at pixel_x 799->0, pixel_y goes 0->1 and video_on returns to 1.
REQ-043 Frame scenario: vsync is low only for pixel_y 490-491 (64 us); at (799,524) the next tick gives (0,0); successive frame starts are 16.8 ms apart.
REQ-044 Mid-operation reset: assert reset for 1 clk at pixel_x=300, pixel_y=100 -> next edge gives 0/0, hsync=vsync=1, and the tick divider restarts (first utick 4 clk later).

Source files
------------

// File: rtl/vga_sync_pkg.sv
// Shared VGA 640x480@60 timing constants and small decode helpers.
// Everything here is the default mode; vga_sync re-derives totals from its own parameters.
package vga_sync_pkg;

  localparam int unsigned CNT_W     = 10;
  localparam int unsigned PIXEL_DIV = 4;

  localparam int unsigned H_DISP    = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_RETRACE = 96;
  localparam int unsigned H_BACK    = 48;

  localparam int unsigned V_DISP    = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_RETRACE = 2;
  localparam int unsigned V_BACK    = 33;

  localparam int unsigned H_TOTAL      = H_DISP + H_FRONT + H_RETRACE + H_BACK;
  localparam int unsigned V_TOTAL      = V_DISP + V_FRONT + V_RETRACE + V_BACK;
  localparam int unsigned H_SYNC_START = H_DISP + H_FRONT;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_RETRACE - 1;
  localparam int unsigned V_SYNC_START = V_DISP + V_FRONT;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_RETRACE - 1;

  // Inclusive window test used for the active-low sync decodes.
  function automatic logic in_window(input int unsigned v, input int unsigned lo,
                                     input int unsigned hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_mod_counter.sv
// Modulo-N counter with enable and synchronous reset; wrap flags the enabled
// cycle on which the count returns to zero.
module vga_mod_counter #(
  parameter int unsigned N = 4,
  parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] count_next;

  always_comb begin
    wrap       = en && (count == LAST);
    count_next = count;
    if (en) begin
      count_next = (count == LAST) ? '0 : count + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/vga_sync.sv
// VGA sync generator: pixel-rate divider, horizontal/vertical scan counters,
// registered active-low syncs and a combinational visible-area flag.
module vga_sync
  import vga_sync_pkg::*;
#(
  parameter int unsigned HD       = H_DISP,
  parameter int unsigned HF       = H_FRONT,
  parameter int unsigned HR       = H_RETRACE,
  parameter int unsigned HB       = H_BACK,
  parameter int unsigned VD       = V_DISP,
  parameter int unsigned VF       = V_FRONT,
  parameter int unsigned VR       = V_RETRACE,
  parameter int unsigned VB       = V_BACK,
  parameter int unsigned TICK_DIV = PIXEL_DIV
) (
  input  logic             clk,
  input  logic             reset,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             utick,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y
);

  localparam int unsigned H_TOT = HD + HF + HR + HB;
  localparam int unsigned V_TOT = VD + VF + VR + VB;
  localparam int unsigned HS_LO = HD + HF;
  localparam int unsigned HS_HI = HD + HF + HR - 1;
  localparam int unsigned VS_LO = VD + VF;
  localparam int unsigned VS_HI = VD + VF + VR - 1;
  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] HD_L     = CNT_W'(HD);
  localparam logic [CNT_W-1:0] VD_L     = CNT_W'(VD);

  logic [DIV_W-1:0] div_count;
  logic             div_wrap_unused;
  logic             h_wrap;
  logic             v_wrap_unused;
  logic [CNT_W-1:0] x_next;
  logic [CNT_W-1:0] y_next;

  vga_mod_counter #(.N(TICK_DIV), .W(DIV_W)) u_div (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .count (div_count),
    .wrap  (div_wrap_unused)
  );

  vga_mod_counter #(.N(H_TOT), .W(CNT_W)) u_hcnt (
    .clk   (clk),
    .reset (reset),
    .en    (utick),
    .count (pixel_x),
    .wrap  (h_wrap)
  );

  vga_mod_counter #(.N(V_TOT), .W(CNT_W)) u_vcnt (
    .clk   (clk),
    .reset (reset),
    .en    (h_wrap),
    .count (pixel_y),
    .wrap  (v_wrap_unused)
  );

  assign utick    = (div_count == DIV_LAST);
  assign video_on = (pixel_x < HD_L) && (pixel_y < VD_L);

  // Mirror the counters' next state so the sync flops switch on the same edge
  // as pixel_x/pixel_y instead of one pixel late.
  always_comb begin
    x_next = pixel_x;
    y_next = pixel_y;
    if (utick) begin
      x_next = h_wrap ? '0 : pixel_x + CNT_W'(1);
    end
    if (h_wrap) begin
      y_next = (pixel_y == CNT_W'(V_TOT - 1)) ? '0 : pixel_y + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      hsync <= !in_window(32'(x_next), HS_LO, HS_HI);
      vsync <= !in_window(32'(y_next), VS_LO, VS_HI);
    end
  end

endmodule

// File: tb/tb_vga_sync.sv
// Directed bench for vga_sync: default horizontal timing and tick divider,
// shortened vertical timing (VD=2 VF=1 VR=2 VB=1) so full frames fit in a short run.
module tb_vga_sync;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       hsync, vsync, video_on, utick;
  logic [9:0] pixel_x, pixel_y;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  time         t_rst = 0;
  time         t0 = 0;

  always #5 clk = ~clk;

  vga_sync #(.VD(2), .VF(1), .VR(2), .VB(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .hsync    (hsync),
    .vsync    (vsync),
    .video_on (video_on),
    .utick    (utick),
    .pixel_x  (pixel_x),
    .pixel_y  (pixel_y)
  );

  typedef struct {
    string       name;
    int unsigned n_clk;
    logic        rst;
    int unsigned x;
    int unsigned y;
    logic        hs;
    logic        vs;
    logic        von;
    logic        ut;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Step sample-by-sample until the counters reach the target; a missed target is a failure.
  task automatic adv(input string name, input int unsigned tx, input int unsigned ty,
                     input logic use_y, input int unsigned budget);
    int unsigned k = 0;
    while (!(pixel_x == 10'(tx) && (!use_y || pixel_y == 10'(ty))) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!(pixel_x == 10'(tx) && (!use_y || pixel_y == 10'(ty)))) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timeout at x=%0d y=%0d expected x=%0d y=%0d",
               name, pixel_x, pixel_y, tx, ty);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //            name       n  rst  x  y  hs vs von ut
    vecs.push_back('{"rst1",   1, 1'b1, 0, 0, 1, 1, 1, 0});
    vecs.push_back('{"rst5",   4, 1'b1, 0, 0, 1, 1, 1, 0});
    vecs.push_back('{"rst10",  5, 1'b1, 0, 0, 1, 1, 1, 0});
    vecs.push_back('{"div1",   1, 1'b0, 0, 0, 1, 1, 1, 0});
    vecs.push_back('{"div2",   1, 1'b0, 0, 0, 1, 1, 1, 0});
    vecs.push_back('{"tick1",  1, 1'b0, 0, 0, 1, 1, 1, 1});
    vecs.push_back('{"px1",    1, 1'b0, 1, 0, 1, 1, 1, 0});
    vecs.push_back('{"tick2",  3, 1'b0, 1, 0, 1, 1, 1, 1});
    vecs.push_back('{"px2",    1, 1'b0, 2, 0, 1, 1, 1, 0});
    vecs.push_back('{"tick3",  3, 1'b0, 2, 0, 1, 1, 1, 1});
    vecs.push_back('{"px3",    1, 1'b0, 3, 0, 1, 1, 1, 0});

    foreach (vecs[i]) begin
      reset = vecs[i].rst;
      repeat (vecs[i].n_clk) @(posedge clk);
      @(negedge clk);
      if (vecs[i].rst) t_rst = $time;
      chk({vecs[i].name, ".x"},     32'(pixel_x),  vecs[i].x);
      chk({vecs[i].name, ".y"},     32'(pixel_y),  vecs[i].y);
      chk({vecs[i].name, ".hsync"}, 32'(hsync),    32'(vecs[i].hs));
      chk({vecs[i].name, ".vsync"}, 32'(vsync),    32'(vecs[i].vs));
      chk({vecs[i].name, ".von"},   32'(video_on), 32'(vecs[i].von));
      chk({vecs[i].name, ".utick"}, 32'(utick),    32'(vecs[i].ut));
    end

    // Horizontal sync window and visible-area edge on line 0.
    adv("to655", 655, 0, 1'b0, 5000);
    chk("hs_655", 32'(hsync), 1);
    adv("to656", 656, 0, 1'b0, 100);
    chk("hs_656", 32'(hsync), 0);
    t0 = $time;
    adv("to751", 751, 0, 1'b0, 1000);
    chk("hs_751", 32'(hsync), 0);
    adv("to752", 752, 0, 1'b0, 100);
    chk("hs_752", 32'(hsync), 1);
    chk("hs_low_ns", 32'($time - t0), 3840);

    adv("to799", 799, 0, 1'b0, 1000);
    chk("von_799", 32'(video_on), 0);
    chk("y_799", 32'(pixel_y), 0);
    adv("to0_1", 0, 1, 1'b1, 100);
    chk("von_0_1", 32'(video_on), 1);
    adv("to639_1", 639, 1, 1'b1, 5000);
    chk("von_639", 32'(video_on), 1);
    adv("to640_1", 640, 1, 1'b1, 100);
    chk("von_640", 32'(video_on), 0);

    // Vertical: visible rows 0-1, sync rows 3-4, last row 5.
    adv("to0_2", 0, 2, 1'b1, 5000);
    chk("von_y2", 32'(video_on), 0);
    adv("to799_2", 799, 2, 1'b1, 5000);
    chk("vs_799_2", 32'(vsync), 1);
    adv("to0_3", 0, 3, 1'b1, 100);
    chk("vs_0_3", 32'(vsync), 0);
    t0 = $time;
    adv("to799_4", 799, 4, 1'b1, 10000);
    chk("vs_799_4", 32'(vsync), 0);
    adv("to0_5", 0, 5, 1'b1, 100);
    chk("vs_0_5", 32'(vsync), 1);
    chk("vs_low_ns", 32'($time - t0), 64000);

    adv("to799_5", 799, 5, 1'b1, 5000);
    chk("y_799_5", 32'(pixel_y), 5);
    adv("to0_0", 0, 0, 1'b1, 100);
    chk("wrap_y", 32'(pixel_y), 0);
    chk("wrap_hs", 32'(hsync), 1);
    chk("wrap_vs", 32'(vsync), 1);
    chk("wrap_von", 32'(video_on), 1);
    chk("frame_ns", 32'($time - t_rst), 192000);

    // Mid-frame reset inside both sync windows.
    adv("to700_3", 700, 3, 1'b1, 20000);
    chk("pre_hs", 32'(hsync), 0);
    chk("pre_vs", 32'(vsync), 0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("mrst_x", 32'(pixel_x), 0);
    chk("mrst_y", 32'(pixel_y), 0);
    chk("mrst_hs", 32'(hsync), 1);
    chk("mrst_vs", 32'(vsync), 1);
    chk("mrst_von", 32'(video_on), 1);
    chk("mrst_ut", 32'(utick), 0);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("mrst_ut%0d", k), 32'(utick), (k == 3) ? 1 : 0);
      chk($sformatf("mrst_x%0d", k), 32'(pixel_x), (k == 4) ? 1 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
